// File: rtl/audio_i2s_tx_pkg.sv
// Shared audio framing constants and the I2S slot-to-bit mapping.
package audio_i2s_tx_pkg;

  localparam int SLOT_BITS   = 32;
  localparam int FRAME_SLOTS = 64;
  localparam int SAMPLE_W    = 16;
  localparam int SLOT_W      = $clog2(FRAME_SLOTS);

  localparam logic I2S_LEFT  = 1'b0;
  localparam logic I2S_RIGHT = 1'b1;

  // Slot 0 of each channel is the I2S one-bit delay; slots 1..16 carry MSB..LSB.
  function automatic logic slot_bit(input logic [SAMPLE_W-1:0] word,
                                    input logic [4:0]          k);
    logic [4:0] idx;
    idx = 5'(SAMPLE_W) - k;
    if (k >= 5'd1 && k <= 5'(SAMPLE_W)) return word[idx[3:0]];
    return 1'b0;
  endfunction

endpackage

// File: rtl/audio_i2s_tx_frac_clk_div.sv
// Fractional clock-enable generator: pulses tgl at an average rate of NUM/DEN per clk.
module frac_clk_div #(
  parameter int NUM = 6144000,
  parameter int DEN = 24576000
) (
  input  logic clk,
  input  logic reset,
  input  logic en,
  output logic tgl
);

  localparam int            W     = $clog2(DEN) + 2;
  localparam logic [W-1:0]  NUM_W = W'(NUM);
  localparam logic [W-1:0]  DEN_W = W'(DEN);

  logic [W-1:0] acc;
  logic [W-1:0] sum;

  assign sum = acc + NUM_W;
  assign tgl = en && (sum >= DEN_W);

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)      acc <= '0;
    else if (!en)   acc <= '0;
    else if (tgl)   acc <= sum - DEN_W;
    else            acc <= sum;
  end

endmodule

// File: rtl/audio_i2s_tx.sv
// I2S transmitter: 64-slot stereo frame, BCLK from a fractional divider, sample_req paces upstream.
module audio_i2s_tx
  import audio_i2s_tx_pkg::*;
#(
  parameter int CLK_HZ  = 24576000,
  parameter int SCLK_HZ = 3072000
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                enable,
  input  logic [SAMPLE_W-1:0] left_in,
  input  logic [SAMPLE_W-1:0] right_in,
  output logic                sample_req,
  output logic                i2s_bclk,
  output logic                i2s_lrclk,
  output logic                i2s_data
);

  if (CLK_HZ < 4 * SCLK_HZ) begin : g_bad_ratio
    $error("audio_i2s_tx: CLK_HZ must be at least 4*SCLK_HZ");
  end

  logic              tgl;
  logic              fall;
  logic [SLOT_W-1:0] slot;
  logic [SLOT_W-1:0] slot_nxt;
  logic              wrap;
  logic [SAMPLE_W-1:0] hold_l;
  logic [SAMPLE_W-1:0] hold_r;
  logic [SAMPLE_W-1:0] word;

  frac_clk_div #(
    .NUM (2 * SCLK_HZ),
    .DEN (CLK_HZ)
  ) u_div (
    .clk   (clk),
    .reset (reset),
    .en    (enable),
    .tgl   (tgl)
  );

  // tgl is already gated by enable, so a dropping enable always wins over a pending edge.
  assign fall       = tgl && i2s_bclk;
  assign slot_nxt   = slot + 1'b1;
  assign wrap       = (slot_nxt == '0);
  assign sample_req = fall && wrap;
  assign word       = (slot_nxt[SLOT_W-1] == I2S_RIGHT) ? hold_r : hold_l;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)        i2s_bclk <= 1'b0;
    else if (!enable) i2s_bclk <= 1'b0;
    else if (tgl)     i2s_bclk <= ~i2s_bclk;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      slot      <= SLOT_W'(FRAME_SLOTS - 1);
      i2s_lrclk <= I2S_RIGHT;
      i2s_data  <= 1'b0;
      hold_l    <= '0;
      hold_r    <= '0;
    end else if (fall) begin
      slot      <= slot_nxt;
      i2s_lrclk <= slot_nxt[SLOT_W-1];
      i2s_data  <= slot_bit(word, slot_nxt[4:0]);
      if (wrap) begin
        hold_l <= left_in;
        hold_r <= right_in;
      end
    end
  end

endmodule

// File: tb/tb_audio_i2s_tx.sv
// Directed bench for audio_i2s_tx: framing, latency, reset, enable gating and fractional BCLK.
module tb_audio_i2s_tx;

  logic        clk = 1'b0;
  logic        reset;
  logic        enable;
  logic [15:0] left_in;
  logic [15:0] right_in;
  logic        sample_req, i2s_bclk, i2s_lrclk, i2s_data;
  logic        enable2 = 1'b1;
  logic        req2, bclk2, lrclk2, data2;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  audio_i2s_tx #(.CLK_HZ(24576000), .SCLK_HZ(3072000)) dut (
    .clk        (clk),
    .reset      (reset),
    .enable     (enable),
    .left_in    (left_in),
    .right_in   (right_in),
    .sample_req (sample_req),
    .i2s_bclk   (i2s_bclk),
    .i2s_lrclk  (i2s_lrclk),
    .i2s_data   (i2s_data)
  );

  audio_i2s_tx #(.CLK_HZ(50000000), .SCLK_HZ(3072000)) dut_frac (
    .clk        (clk),
    .reset      (reset),
    .enable     (enable2),
    .left_in    (left_in),
    .right_in   (right_in),
    .sample_req (req2),
    .i2s_bclk   (bclk2),
    .i2s_lrclk  (lrclk2),
    .i2s_data   (data2)
  );

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic wait_req(output int n);
    n = 0;
    while (!sample_req && n < 2000) begin
      @(negedge clk);
      n++;
    end
    if (!sample_req) check("req_timeout", 64'd0, 64'd1);
  endtask

  // Waits for sample_req, then records the 64 bits seen on BCLK rising edges.
  // next_left is driven in the clk after sample_req; drop_at >= 0 drops enable for
  // 100 clk during the BCLK-low phase following that bit.
  task automatic capture_frame(input logic [15:0] next_left, input int drop_at,
                               output int wcnt, output logic [31:0] lw, output logic [31:0] rw,
                               output logic [63:0] lrv, output int bad_bclk,
                               output int bad_req, output int bad_hold);
    int   n, guard;
    logic prev, lr0, d0;
    bit   pend;
    lw = '0; rw = '0; lrv = '0;
    bad_bclk = 0; bad_req = 0; bad_hold = 0;
    n = 0; guard = 0; pend = 1'b0;
    wait_req(wcnt);
    prev = i2s_bclk;
    @(negedge clk);
    left_in = next_left;
    while (n < 64 && guard < 1500) begin
      if (i2s_bclk && !prev) begin
        lrv = {lrv[62:0], i2s_lrclk};
        if (n < 32) lw = {lw[30:0], i2s_data};
        else        rw = {rw[30:0], i2s_data};
        if (n == drop_at) pend = 1'b1;
        n++;
      end else if (pend && !i2s_bclk) begin
        pend   = 1'b0;
        enable = 1'b0;
        lr0    = i2s_lrclk;
        d0     = i2s_data;
        repeat (100) begin
          @(negedge clk);
          if (i2s_bclk)                          bad_bclk++;
          if (sample_req)                        bad_req++;
          if (i2s_lrclk !== lr0 || i2s_data !== d0) bad_hold++;
        end
        enable = 1'b1;
      end
      prev = i2s_bclk;
      if (n < 64) begin
        @(negedge clk);
        guard++;
      end
    end
    if (n < 64) check("capture_timeout", 64'(n), 64'd64);
  endtask

  task automatic measure(input bit sel, input int ncyc, output int hmin, output int hmax,
                         output int rmin, output int rmax, output int rcount,
                         output int first_req, output int last_req);
    logic pb, b, r;
    int   run;
    bit   started;
    hmin = 32'h7fffffff; hmax = 0; rmin = 32'h7fffffff; rmax = 0;
    rcount = 0; first_req = 0; last_req = 0; run = 0; started = 1'b0;
    pb = sel ? bclk2 : i2s_bclk;
    for (int c = 0; c < ncyc; c++) begin
      @(negedge clk);
      b = sel ? bclk2 : i2s_bclk;
      r = sel ? req2  : sample_req;
      run++;
      if (b != pb) begin
        if (started) begin
          if (run < hmin) hmin = run;
          if (run > hmax) hmax = run;
        end
        started = 1'b1;
        run = 0;
      end
      pb = b;
      if (r) begin
        rcount++;
        if (rcount == 1) first_req = c;
        else begin
          if (c - last_req < rmin) rmin = c - last_req;
          if (c - last_req > rmax) rmax = c - last_req;
        end
        last_req = c;
      end
    end
  endtask

  localparam logic [63:0] LR_FRAME = 64'h00000000_FFFFFFFF;

  initial begin
    int          wcnt, bb, br, bh;
    int          hmin, hmax, rmin, rmax, rcnt, freq, lreq;
    longint      lo, total;
    logic [31:0] lw, rw;
    logic [63:0] lrv;

    reset    = 1'b1;
    enable   = 1'b1;
    left_in  = 16'hA5C3;
    right_in = 16'h8001;
    repeat (3) @(negedge clk);
    check("rst_bclk",  64'(i2s_bclk),   64'd0);
    check("rst_lrclk", 64'(i2s_lrclk),  64'd1);
    check("rst_data",  64'(i2s_data),   64'd0);
    check("rst_req",   64'(sample_req), 64'd0);

    // First frame after reset: req at the first falling edge, 7 clk after release.
    reset = 1'b0;
    capture_frame(16'hA5C3, -1, wcnt, lw, rw, lrv, bb, br, bh);
    check("first_req_lat", 64'(wcnt), 64'd7);
    check("f1_left",  64'(lw),  64'({1'b0, 16'hA5C3, 15'd0}));
    check("f1_right", 64'(rw),  64'({1'b0, 16'h8001, 15'd0}));
    check("f1_lrclk", lrv, LR_FRAME);

    measure(1'b0, 1600, hmin, hmax, rmin, rmax, rcnt, freq, lreq);
    check("bclk_half_min", 64'(hmin), 64'd4);
    check("bclk_half_max", 64'(hmax), 64'd4);
    check("req_int_min",   64'(rmin), 64'd512);
    check("req_int_max",   64'(rmax), 64'd512);

    // Changing left_in right after sample_req must not disturb the frame in flight.
    capture_frame(16'h7FFF, -1, wcnt, lw, rw, lrv, bb, br, bh);
    check("chg_cur_left", 64'(lw), 64'({1'b0, 16'hA5C3, 15'd0}));
    capture_frame(16'h7FFF, -1, wcnt, lw, rw, lrv, bb, br, bh);
    check("chg_next_left",  64'(lw), 64'({1'b0, 16'h7FFF, 15'd0}));
    check("chg_next_right", 64'(rw), 64'({1'b0, 16'h8001, 15'd0}));

    // Reset at slot 20 of the left channel.
    wait_req(wcnt);
    repeat (20 * 8 + 4) @(negedge clk);
    check("mid_lrclk_left", 64'(i2s_lrclk), 64'd0);
    reset = 1'b1;
    #1;
    check("mid_rst_bclk",  64'(i2s_bclk),   64'd0);
    check("mid_rst_lrclk", 64'(i2s_lrclk),  64'd1);
    check("mid_rst_data",  64'(i2s_data),   64'd0);
    check("mid_rst_req",   64'(sample_req), 64'd0);
    @(negedge clk);
    @(negedge clk);
    left_in  = 16'h1234;
    right_in = 16'hFEDC;
    reset    = 1'b0;
    capture_frame(16'h1234, -1, wcnt, lw, rw, lrv, bb, br, bh);
    check("post_rst_req_lat", 64'(wcnt), 64'd7);
    check("post_rst_left",  64'(lw),  64'({1'b0, 16'h1234, 15'd0}));
    check("post_rst_right", 64'(rw),  64'({1'b0, 16'hFEDC, 15'd0}));
    check("post_rst_lrclk", lrv, LR_FRAME);

    // Enable dropped for 100 clk in the right channel during a BCLK-low phase.
    capture_frame(16'h1234, 40, wcnt, lw, rw, lrv, bb, br, bh);
    check("dis_bclk_high", 64'(bb), 64'd0);
    check("dis_req_seen",  64'(br), 64'd0);
    check("dis_hold_move", 64'(bh), 64'd0);
    check("dis_left",  64'(lw),  64'({1'b0, 16'h1234, 15'd0}));
    check("dis_right", 64'(rw),  64'({1'b0, 16'hFEDC, 15'd0}));
    check("dis_lrclk", lrv, LR_FRAME);

    // 50 MHz clock: half-periods 8/9 clk, frame rate exact to within one clk overall.
    measure(1'b1, 42000, hmin, hmax, rmin, rmax, rcnt, freq, lreq);
    check("frac_half_min", 64'(hmin), 64'd8);
    check("frac_half_max", 64'(hmax), 64'd9);
    lo    = (longint'(rcnt - 1) * 64'd50000000) / 64'd48000;
    total = longint'(lreq - freq);
    check("frac_frame_total", 64'((rcnt >= 30) && (total >= lo) && (total <= lo + 1)), 64'd1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
